ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter; the outbound half of the keyboard link, complementing the existing PS/2 receiver.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_line_filter.sv | 49 ++++
 rtl/ps2_host_tx.sv | 153 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and command codes for the PS/2 host-to-device link.
package ps2_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StInhibit,
        StRts,
        StData,
        StParity,
        StStop,
        StAck,
        StWaitIdle,
        StErr
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a stable-count filter for one PS/2 pad.
// Emits the filtered level and a 1-cycle strobe on each filtered falling edge.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic fall
);
    localparam int unsigned    CntW   = $clog2(FILTER_LEN + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // The new value must differ from the filtered level FILTER_LEN cycles in a row.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q >= CntMax) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign fall  = level_q & ~level_d;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked frame, ACK check.
// Pads are driven through drive-low enables; the tristate buffers live one level up.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned BIT_TIMEOUT    = 100000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    input  logic       psClk,
    input  logic       psData,
    output logic       ps_clk_drive_low,
    output logic       ps_dat_drive_low
);
    localparam int unsigned TmrMax = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
    localparam int unsigned InhW   = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);
    localparam logic [InhW-1:0] InhLoad   = InhW'(INHIBIT_CYCLES - 1);
    localparam logic [TmrW-1:0] StartLoad = TmrW'(START_TIMEOUT);
    localparam logic [TmrW-1:0] BitLoad   = TmrW'(BIT_TIMEOUT);

    ps2_tx_state_t   state_q, state_d;
    logic [7:0]      data_q, data_d;
    logic            parity_q, parity_d;
    logic [2:0]      idx_q, idx_d;
    logic [InhW-1:0] inh_q, inh_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic            clk_drive_q, clk_drive_d;
    logic            dat_drive_q, dat_drive_d;
    logic            clk_level, clk_fall, dat_level, dat_fall_unused;
    logic            accept, timed, wire_bit;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk  (Clk),
        .rst_n(reset_n),
        .raw  (psClk),
        .level(clk_level),
        .fall (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk  (Clk),
        .rst_n(reset_n),
        .raw  (psData),
        .level(dat_level),
        .fall (dat_fall_unused)
    );

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            data_q      <= '0;
            parity_q    <= 1'b0;
            idx_q       <= '0;
            inh_q       <= '0;
            tmr_q       <= '0;
            clk_drive_q <= 1'b0;
            dat_drive_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            parity_q    <= parity_d;
            idx_q       <= idx_d;
            inh_q       <= inh_d;
            tmr_q       <= tmr_d;
            clk_drive_q <= clk_drive_d;
            dat_drive_q <= dat_drive_d;
        end
    end

    assign accept = tx_valid && (state_q == StIdle);
    assign timed  = state_q inside {StRts, StData, StParity, StStop, StAck, StWaitIdle};

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        parity_d = parity_q;
        idx_d    = idx_q;
        inh_d    = inh_q;
        tmr_d    = tmr_q;
        unique case (state_q)
            StIdle: if (accept) begin
                data_d   = tx_data;
                parity_d = ~^tx_data;
                idx_d    = '0;
                inh_d    = InhLoad;
                state_d  = StInhibit;
            end
            StInhibit: if (inh_q == '0) begin
                state_d = StRts;
                tmr_d   = StartLoad;
            end else begin
                inh_d = inh_q - 1'b1;
            end
            // The first device edge already shifts out bit 0.
            StRts: if (clk_fall) begin
                idx_d   = 3'd1;
                state_d = StData;
            end
            StData: if (clk_fall) begin
                if (idx_q == 3'd7) begin
                    state_d = StParity;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            StParity:   if (clk_fall) state_d = StStop;
            StStop:     if (clk_fall) state_d = StAck;
            StAck:      if (clk_fall) state_d = dat_level ? StErr : StWaitIdle;
            StWaitIdle: if (clk_level && dat_level) state_d = StIdle;
            StErr:      state_d = StIdle;
            default:    state_d = StIdle;
        endcase

        if (timed) begin
            if (clk_fall && (state_q != StWaitIdle)) begin
                tmr_d = BitLoad;
            end else if (tmr_q != '0) begin
                tmr_d = tmr_q - 1'b1;
            end else if (state_d != StIdle) begin
                state_d = StErr;
            end
        end
    end

    always_comb begin
        clk_drive_d = (state_d == StInhibit);
        wire_bit    = (state_q == StParity) ? parity_q : data_q[idx_q];
        unique case (state_d)
            StInhibit:                dat_drive_d = (inh_d == '0);
            StRts:                    dat_drive_d = 1'b1;
            StData, StParity, StStop: dat_drive_d = clk_fall ? ~wire_bit : dat_drive_q;
            default:                  dat_drive_d = 1'b0;
        endcase
        tx_ready = (state_q == StIdle);
        busy     = (state_q != StIdle);
        tx_err   = (state_q == StErr);
        tx_done  = (state_q == StWaitIdle) && clk_level && dat_level;
    end

    assign ps_clk_drive_low = clk_drive_q;
    assign ps_dat_drive_low = dat_drive_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device BFM clocks frames out, scoreboard matches done/err responses.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 20;
    localparam int unsigned STO  = 200;
    localparam int unsigned BTO  = 100;
    localparam int unsigned FL   = 2;
    localparam int unsigned HALF = 40;

    logic       Clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, busy;
    logic       ps_clk_drive_low, ps_dat_drive_low;
    logic       bfm_clk_low = 1'b0;
    logic       bfm_dat_low = 1'b0;
    logic       glitch = 1'b0;
    logic       psClk, psData;

    int checks = 0;
    int failures = 0;
    bit exp_q[$];  // 1 = expect tx_done, 0 = expect tx_err

    // Open-drain lines: low if anyone pulls low.
    assign psClk  = !(ps_clk_drive_low || bfm_clk_low || glitch);
    assign psData = !(ps_dat_drive_low || bfm_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (STO),
        .BIT_TIMEOUT   (BTO),
        .FILTER_LEN    (FL)
    ) dut (
        .Clk             (Clk),
        .reset_n         (reset_n),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_done         (tx_done),
        .tx_err          (tx_err),
        .busy            (busy),
        .psClk           (psClk),
        .psData          (psData),
        .ps_clk_drive_low(ps_clk_drive_low),
        .ps_dat_drive_low(ps_dat_drive_low)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as the device sees it: start, 8 data LSB first, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        logic p;
        p = (($countones(d) % 2) == 0);
        return {1'b1, p, d, 1'b0};
    endfunction

    always @(negedge Clk) begin
        bit want_done;
        if (tx_done || tx_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_response", {30'd0, tx_done, tx_err}, 32'd0);
            end else begin
                want_done = exp_q.pop_front();
                check("response_kind", {30'd0, tx_done, tx_err}, want_done ? 32'd2 : 32'd1);
            end
        end
    end

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        while (!tx_ready && n < 2000) begin
            @(posedge Clk);
            n++;
        end
        if (!tx_ready) check("ready_before_send", 0, 1);
        @(posedge Clk);
        #1 tx_data = d;
        tx_valid = 1'b1;
        @(posedge Clk);
        #1 tx_valid = 1'b0;
    endtask

    // mode 0: ACK, 1: data left high at edge 11, 2: device never clocks.
    task automatic device_rx(input logic [7:0] d, input int mode, input int glitch_edge,
                             input int abort_edge);
        logic [10:0] got;
        int n;
        got = '0;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!ps_clk_drive_low && n < 2000);
        if (!ps_clk_drive_low) begin
            check("inhibit_seen", 0, 1);
            return;
        end
        n = 0;
        while (ps_clk_drive_low && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        check("inhibit_len", n, INH);

        if (mode == 2) begin
            n = 0;
            while (!tx_err && n < 400) begin
                @(negedge Clk);
                n++;
            end
            check("start_timeout_window", {31'd0, (n >= STO) && (n <= STO + FL + 4)}, 1);
            @(negedge Clk);
            check("timeout_lines_released", {30'd0, ps_clk_drive_low, ps_dat_drive_low}, 0);
            return;
        end

        got[0] = psData;
        for (int e = 1; e <= 11; e++) begin
            #1 bfm_dat_low = (e == 11) && (mode == 0);
            repeat (HALF / 2) @(posedge Clk);
            if (e == glitch_edge) begin
                #1 glitch = 1'b1;
                @(posedge Clk);
                #1 glitch = 1'b0;
            end
            repeat (HALF / 2) @(posedge Clk);
            #1 bfm_clk_low = 1'b1;
            repeat (HALF) @(posedge Clk);
            if (e == abort_edge) begin
                check("abort_data_driven", ps_dat_drive_low, 1);
                @(posedge Clk);
                #2 reset_n = 1'b0;
                #1;
                check("reset_clk_release", ps_clk_drive_low, 0);
                check("reset_dat_release", ps_dat_drive_low, 0);
                bfm_clk_low = 1'b0;
                repeat (3) @(posedge Clk);
                #1 reset_n = 1'b1;
                repeat (10) @(negedge Clk);
                check("ready_after_reset", tx_ready, 1);
                check("idle_after_reset", busy, 0);
                return;
            end
            if (e <= 10) got[e] = psData;
            #1 bfm_clk_low = 1'b0;
        end
        repeat (5) @(posedge Clk);
        #1 bfm_dat_low = 1'b0;
        check("frame_bits", got, ref_frame(d));
        n = 0;
        while (busy && n < 300) begin
            @(negedge Clk);
            n++;
        end
        check("ready_after_frame", tx_ready, 1);
        check("lines_released", {30'd0, ps_clk_drive_low, ps_dat_drive_low}, 0);
    endtask

    task automatic busy_pulses();
        repeat (150) @(posedge Clk);
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1 tx_valid = 1'b1;
            tx_data = 8'($urandom);
            @(posedge Clk);
            #1 tx_valid = 1'b0;
            repeat (50) @(posedge Clk);
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input int mode, input int abort_edge,
                             input int glitch_edge, input bit pulse_busy);
        int n;
        if (abort_edge == 0) exp_q.push_back(mode == 0);
        send(d);
        fork
            device_rx(d, mode, glitch_edge, abort_edge);
            if (pulse_busy) busy_pulses();
        join
        if (pulse_busy) begin
            n = 0;
            repeat (150) begin
                @(negedge Clk);
                if (ps_clk_drive_low) n++;
            end
            check("no_queued_frame", n, 0);
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_tx_err", tx_err, 0);
        check("rst_clk_drive", ps_clk_drive_low, 0);
        check("rst_dat_drive", ps_dat_drive_low, 0);
        reset_n = 1'b1;
        repeat (5) @(posedge Clk);

        run_frame(8'hED, 0, 0, 0, 1'b0);
        run_frame(8'h01, 0, 0, 0, 1'b0);
        run_frame(8'hFF, 0, 0, 0, 1'b0);
        run_frame(8'h00, 0, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) run_frame(8'($urandom), 0, 0, 0, 1'b0);
        run_frame(8'h5A, 1, 0, 0, 1'b0);
        run_frame(8'hC3, 2, 0, 0, 1'b0);
        run_frame(8'h00, 0, 4, 0, 1'b0);
        run_frame(8'hFF, 0, 0, 0, 1'b0);
        run_frame(8'hA6, 0, 0, 3, 1'b1);

        repeat (20) @(negedge Clk);
        check("all_responses_seen", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
